// File: rtl/hazard_pkg_r1.sv
// Shared definitions for the forwarding and hazard-control unit.
// Forward-select encodings and a constant width helper.
package hazard_pkg_r1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/forward_select_r1.sv
// Forward select for one EX-stage source operand.
// MEM wins over WB; register 0 always reads the register file.
module forward_select_r1
    import hazard_pkg_r1::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] i_src,
    input  logic          i_mem_we,
    input  logic [AW-1:0] i_mem_rd,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_rd,
    output logic [1:0]    o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_src != '0) begin
            if (i_mem_we && (i_src == i_mem_rd)) begin
                o_sel = FWD_MEM;
            end else if (i_wb_we && (i_src == i_wb_rd)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forwarding_unit_r1.sv
// Forwarding selects, load-use and HI/LO hazard stalls, mult/div busy
// tracking and a saturating stall counter for the pipelined MIPS core.
module hazard_forwarding_unit_r1
    import hazard_pkg_r1::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 2,
    parameter int MULDIV_LAT     = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_src,
    input  logic [NUM_SRC-1:0]                id_src_used,
    input  logic                              id_is_muldiv,
    input  logic                              id_reads_hilo,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] ex_src,
    input  logic                              ex_writeReg,
    input  logic [REG_ADDR_WIDTH-1:0]         ex_regToWrite,
    input  logic                              ex_memRead,
    input  logic                              mem_writeReg,
    input  logic [REG_ADDR_WIDTH-1:0]         mem_regToWrite,
    input  logic                              wb_writeReg,
    input  logic [REG_ADDR_WIDTH-1:0]         wb_regToWrite,
    output logic [2*NUM_SRC-1:0]              forward,
    output logic                              stall,
    output logic                              bubble_ex,
    output logic                              muldiv_busy,
    output logic [CNT_WIDTH-1:0]              stall_count
);

    localparam int AW = REG_ADDR_WIDTH;
    localparam int BW = clog2(MULDIV_LAT + 1);

    logic [BW-1:0]        r_busy_cnt;
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic                 w_load_use;
    logic                 w_hilo;
    logic                 w_stall;
    logic                 w_issue;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        forward_select_r1 #(.AW(AW)) u_sel (
            .i_src    (ex_src[i*AW +: AW]),
            .i_mem_we (mem_writeReg),
            .i_mem_rd (mem_regToWrite),
            .i_wb_we  (wb_writeReg),
            .i_wb_rd  (wb_regToWrite),
            .o_sel    (forward[2*i +: 2])
        );
    end

    always_comb begin
        w_load_use = 1'b0;
        if (id_valid && ex_memRead && ex_writeReg && (ex_regToWrite != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (id_src_used[i] && (id_src[i*AW +: AW] == ex_regToWrite)) begin
                    w_load_use = 1'b1;
                end
            end
        end
    end

    assign muldiv_busy = (r_busy_cnt != '0);
    assign w_hilo      = id_valid && muldiv_busy && (id_is_muldiv || id_reads_hilo);
    assign w_stall     = w_load_use || w_hilo;
    assign w_issue     = id_valid && id_is_muldiv && !w_stall;
    assign stall       = w_stall;
    assign bubble_ex   = w_stall;
    assign stall_count = r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if (w_issue) begin
            r_busy_cnt <= BW'(MULDIV_LAT);
        end else if (r_busy_cnt != '0) begin
            r_busy_cnt <= r_busy_cnt - BW'(1);
        end
    end

    // Saturates at all-ones so a long stall never reads as a short one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forwarding_unit_r1.sv
// Self-checking bench: directed vectors, a per-cycle reference model
// and hand-computed literal checks.
module tb_hazard_forwarding_unit_r1;

    localparam int AW  = 5;
    localparam int NS  = 2;
    localparam int LAT = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [NS*AW-1:0]  id_src;
    logic [NS-1:0]     id_src_used;
    logic              id_is_muldiv;
    logic              id_reads_hilo;
    logic [NS*AW-1:0]  ex_src;
    logic              ex_writeReg;
    logic [AW-1:0]     ex_regToWrite;
    logic              ex_memRead;
    logic              mem_writeReg;
    logic [AW-1:0]     mem_regToWrite;
    logic              wb_writeReg;
    logic [AW-1:0]     wb_regToWrite;
    logic [2*NS-1:0]   forward;
    logic              stall;
    logic              bubble_ex;
    logic              muldiv_busy;
    logic [CW-1:0]     stall_count;

    int checks = 0;
    int errors = 0;
    int m_busy = 0;
    int m_cnt = 0;
    bit m_ok = 0;

    always #5 clk = ~clk;

    hazard_forwarding_unit_r1 #(
        .REG_ADDR_WIDTH (AW),
        .NUM_SRC        (NS),
        .MULDIV_LAT     (LAT),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_src         (id_src),
        .id_src_used    (id_src_used),
        .id_is_muldiv   (id_is_muldiv),
        .id_reads_hilo  (id_reads_hilo),
        .ex_src         (ex_src),
        .ex_writeReg    (ex_writeReg),
        .ex_regToWrite  (ex_regToWrite),
        .ex_memRead     (ex_memRead),
        .mem_writeReg   (mem_writeReg),
        .mem_regToWrite (mem_regToWrite),
        .wb_writeReg    (wb_writeReg),
        .wb_regToWrite  (wb_regToWrite),
        .forward        (forward),
        .stall          (stall),
        .bubble_ex      (bubble_ex),
        .muldiv_busy    (muldiv_busy),
        .stall_count    (stall_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int addr_of(input logic [NS*AW-1:0] bus, input int i);
        return int'((bus >> (AW * i)) & ((1 << AW) - 1));
    endfunction

    function automatic int exp_fwd();
        int r;
        r = 0;
        for (int i = 0; i < NS; i++) begin
            int a;
            int s;
            a = addr_of(ex_src, i);
            s = 0;
            if (a != 0 && mem_writeReg && a == int'(mem_regToWrite)) s = 1;
            else if (a != 0 && wb_writeReg && a == int'(wb_regToWrite)) s = 2;
            r = r + (s << (2 * i));
        end
        return r;
    endfunction

    function automatic bit exp_stall();
        bit lu;
        bit hl;
        lu = 0;
        if (id_valid && ex_memRead && ex_writeReg && ex_regToWrite != 0)
            for (int i = 0; i < NS; i++)
                if (id_src_used[i] && addr_of(id_src, i) == int'(ex_regToWrite)) lu = 1;
        hl = id_valid && (m_busy > 0) && (id_is_muldiv || id_reads_hilo);
        return lu || hl;
    endfunction

    always @(posedge clk) begin
        bit st;
        st = exp_stall();
        if (rst) begin
            m_busy = 0;
            m_cnt = 0;
            m_ok = 1;
        end else begin
            if (id_valid && id_is_muldiv && !st) m_busy = LAT;
            else if (m_busy > 0) m_busy = m_busy - 1;
            if (st && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_fwd", 32'(forward), 32'(exp_fwd()));
            chk("model_stall", 32'(stall), 32'(exp_stall()));
            chk("model_bubble", 32'(bubble_ex), 32'(exp_stall()));
            chk("model_busy", 32'(muldiv_busy), 32'(m_busy != 0));
            chk("model_cnt", 32'(stall_count), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_src = '0; id_src_used = '0;
        id_is_muldiv = 0; id_reads_hilo = 0; ex_src = '0;
        ex_writeReg = 0; ex_regToWrite = '0; ex_memRead = 0;
        mem_writeReg = 0; mem_regToWrite = '0;
        wb_writeReg = 0; wb_regToWrite = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_load_use(input int rd);
        ex_memRead = 1; ex_writeReg = 1; ex_regToWrite = AW'(rd);
        id_valid = 1; id_src = {AW'(rd), AW'(9)}; id_src_used = 2'b10;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        chk("reset_busy", 32'(muldiv_busy), 0);
        chk("reset_cnt", 32'(stall_count), 0);
        chk("reset_stall", 32'(stall), 0);

        ex_src = {AW'(7), AW'(3)};
        mem_writeReg = 1; mem_regToWrite = 3;
        wb_writeReg = 1; wb_regToWrite = 3;
        #1 chk("fwd_mem_prio", 32'(forward), 32'h1);
        tick();
        mem_writeReg = 0;
        #1 chk("fwd_wb", 32'(forward), 32'h2);
        tick();
        wb_regToWrite = 7;
        #1 chk("fwd_src1_wb", 32'(forward), 32'h8);
        tick();
        ex_src = {AW'(0), AW'(0)};
        mem_writeReg = 1; mem_regToWrite = 0;
        wb_regToWrite = 0;
        #1 chk("fwd_zero", 32'(forward), 32'h0);
        tick();

        do_reset();
        set_load_use(5);
        #1 chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble_ex), 1);
        tick();
        ex_memRead = 0; ex_writeReg = 0;
        mem_writeReg = 1; mem_regToWrite = 5;
        ex_src = {AW'(5), AW'(9)};
        #1 chk("lu_released", 32'(stall), 0);
        chk("lu_fwd_mem", 32'(forward), 32'h4);
        chk("lu_cnt", 32'(stall_count), 1);
        tick();
        set_load_use(5);
        id_src_used = 2'b00;
        #1 chk("lu_unused", 32'(stall), 0);
        tick();

        do_reset();
        id_valid = 1; id_is_muldiv = 1;
        #1 chk("md_issue_nostall", 32'(stall), 0);
        tick();
        id_valid = 0; id_is_muldiv = 0;
        #1 chk("md_busy_c1", 32'(muldiv_busy), 1);
        tick();
        id_valid = 1; id_reads_hilo = 1;
        for (int c = 2; c <= 4; c++) begin
            #1 chk("md_hilo_stall", 32'(stall), 1);
            chk("md_busy", 32'(muldiv_busy), 1);
            tick();
        end
        #1 chk("md_c5_busy", 32'(muldiv_busy), 0);
        chk("md_c5_stall", 32'(stall), 0);
        chk("md_c5_cnt", 32'(stall_count), 3);
        tick();

        do_reset();
        id_valid = 1; id_is_muldiv = 1;
        tick();
        id_is_muldiv = 0;
        set_load_use(6);
        id_reads_hilo = 1;
        #1 chk("both_stall", 32'(stall), 1);
        tick();
        idle();
        #1 chk("both_cnt", 32'(stall_count), 1);
        tick();

        do_reset();
        set_load_use(4);
        for (int c = 0; c < 20; c++) tick();
        idle();
        #1 chk("sat_cnt", 32'(stall_count), 15);
        tick();
        #1 chk("sat_hold", 32'(stall_count), 15);

        do_reset();
        id_valid = 1; id_is_muldiv = 1;
        tick();
        idle();
        tick();
        id_valid = 1; id_reads_hilo = 1;
        tick();
        rst = 1;
        #1 chk("rst_pre_busy", 32'(muldiv_busy), 1);
        chk("rst_pre_cnt", 32'(stall_count), 1);
        tick();
        rst = 0;
        #1 chk("rst_busy", 32'(muldiv_busy), 0);
        chk("rst_cnt", 32'(stall_count), 0);
        chk("rst_mflo_nostall", 32'(stall), 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
